// File: rtl/rc_seq_pkg.sv
// Shared types and register map for the ripple-counter sequencer.
// State encoding, Wishbone register offsets and CTRL/STATUS bit positions.
package rc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DIV    = 2'd1;
  localparam logic [1:0] REG_NPULSE = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_START        = 0;
  localparam int CTRL_STOP         = 1;
  localparam int CTRL_AUTO_RELOAD  = 2;
  localparam int CTRL_CLR_ON_START = 3;
  localparam int CTRL_IRQ_EN       = 4;

  localparam int STATUS_BUSY       = 0;
  localparam int STATUS_DONE       = 1;
  localparam int STATUS_ISSUED_LSB = 8;

  // Merge a 32-bit write into an existing value, byte lane by byte lane.
  function automatic logic [31:0] apply_sel(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rc_seq_wb_regs.sv
// Wishbone slave and register file for the sequencer: CTRL/DIV/NPULSE/STATUS,
// one-cycle start/stop strobes from CTRL writes, sticky done with W1C.
module rc_seq_wb_regs
  import rc_seq_pkg::*;
#(
  parameter int DIV_W    = 16,
  parameter int NPULSE_W = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [1:0]          reg_adr,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  output logic                start_o,
  output logic                stop_o,
  output logic                auto_reload_o,
  output logic                clr_on_start_o,
  output logic [DIV_W-1:0]    div_o,
  output logic [NPULSE_W-1:0] npulse_o,
  input  logic                busy_i,
  input  logic                done_set_i,
  input  logic [NPULSE_W-1:0] issued_i,
  output logic                irq_o
);

  logic        irq_en_q;
  logic        done_q;
  logic        req;
  logic        wr;
  logic [31:0] rd_data;

  // The ack itself blocks the request, which guarantees a gap between acks.
  assign req   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr    = req & wbs_we_i;
  assign irq_o = done_q & irq_en_q;

  // NOTE: every variable in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    rd_data = '0;
    case (reg_adr)
      REG_CTRL: begin
        rd_data[CTRL_AUTO_RELOAD]  = auto_reload_o;
        rd_data[CTRL_CLR_ON_START] = clr_on_start_o;
        rd_data[CTRL_IRQ_EN]       = irq_en_q;
      end
      REG_DIV:    rd_data[DIV_W-1:0]    = div_o;
      REG_NPULSE: rd_data[NPULSE_W-1:0] = npulse_o;
      default: begin
        rd_data[STATUS_BUSY]                      = busy_i;
        rd_data[STATUS_DONE]                      = done_q;
        rd_data[STATUS_ISSUED_LSB +: NPULSE_W]    = issued_i;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o      <= 1'b0;
      wbs_dat_o      <= '0;
      start_o        <= 1'b0;
      stop_o         <= 1'b0;
      auto_reload_o  <= 1'b0;
      clr_on_start_o <= 1'b0;
      irq_en_q       <= 1'b0;
      div_o          <= '0;
      npulse_o       <= '0;
      done_q         <= 1'b0;
    end else begin
      wbs_ack_o <= req;
      start_o   <= 1'b0;
      stop_o    <= 1'b0;
      if (req) wbs_dat_o <= rd_data;
      if (wr) begin
        case (reg_adr)
          REG_CTRL: if (wbs_sel_i[0]) begin
            start_o        <= wbs_dat_i[CTRL_START];
            stop_o         <= wbs_dat_i[CTRL_STOP];
            auto_reload_o  <= wbs_dat_i[CTRL_AUTO_RELOAD];
            clr_on_start_o <= wbs_dat_i[CTRL_CLR_ON_START];
            irq_en_q       <= wbs_dat_i[CTRL_IRQ_EN];
          end
          REG_DIV:    div_o    <= DIV_W'(apply_sel(32'(div_o), wbs_dat_i, wbs_sel_i));
          REG_NPULSE: npulse_o <= NPULSE_W'(apply_sel(32'(npulse_o), wbs_dat_i, wbs_sel_i));
          default: ;
        endcase
      end
      // A completing burst outranks a simultaneous software clear.
      if (done_set_i) begin
        done_q <= 1'b1;
      end else if (wr && reg_adr == REG_STATUS && wbs_sel_i[0] && wbs_dat_i[STATUS_DONE]) begin
        done_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ripple_counter_seq.sv
// Wishbone-programmed burst sequencer for the user-area ripple counter.
// Optional hardware start input enabled by defining RC_SEQ_EXT_TRIG_EN.
module ripple_counter_seq
  import rc_seq_pkg::*;
#(
  parameter int DIV_W    = 16,
  parameter int NPULSE_W = 16,
  parameter int CLR_CYC  = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        cnt_pulse_o,
  output logic        cnt_clr_o,
  output logic        busy_o,
  output logic        irq_o
`ifdef RC_SEQ_EXT_TRIG_EN
  ,
  input  logic        ext_trig_i
`endif
);

  localparam int CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

  state_e              state;
  logic                start_cmd, stop_cmd, auto_reload, clr_on_start;
  logic [DIV_W-1:0]    div_reg, div_sh, div_cnt, period_max;
  logic [NPULSE_W-1:0] npulse_reg, npulse_sh, issued, issued_inc;
  logic [CLR_W-1:0]    clr_cnt;
  logic                trig_rise, start_evt, launch;
  logic                unused_adr;

  assign unused_adr = &{1'b0, wbs_adr_i[31:4], wbs_adr_i[1:0]};

  rc_seq_wb_regs #(.DIV_W(DIV_W), .NPULSE_W(NPULSE_W)) u_regs (
    .wb_clk_i       (wb_clk_i),
    .wb_rst_ni      (wb_rst_ni),
    .wbs_cyc_i      (wbs_cyc_i),
    .wbs_stb_i      (wbs_stb_i),
    .wbs_we_i       (wbs_we_i),
    .wbs_sel_i      (wbs_sel_i),
    .reg_adr        (wbs_adr_i[3:2]),
    .wbs_dat_i      (wbs_dat_i),
    .wbs_ack_o      (wbs_ack_o),
    .wbs_dat_o      (wbs_dat_o),
    .start_o        (start_cmd),
    .stop_o         (stop_cmd),
    .auto_reload_o  (auto_reload),
    .clr_on_start_o (clr_on_start),
    .div_o          (div_reg),
    .npulse_o       (npulse_reg),
    .busy_i         (busy_o),
    .done_set_i     (state == ST_DONE),
    .issued_i       (issued),
    .irq_o          (irq_o)
  );

`ifdef RC_SEQ_EXT_TRIG_EN
  logic [2:0] trig_sync;
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) trig_sync <= '0;
    else            trig_sync <= {trig_sync[1:0], ext_trig_i};
  end
  assign trig_rise = trig_sync[1] & ~trig_sync[2];
`else
  assign trig_rise = 1'b0;
`endif

  assign start_evt  = start_cmd | trig_rise;
  assign period_max = (div_sh == '0) ? DIV_W'(1) : div_sh;
  assign issued_inc = (issued == '1) ? issued : issued + NPULSE_W'(1);
  assign busy_o     = (state == ST_CLEAR) || (state == ST_RUN);
  // A burst begins from IDLE on an unopposed start, or straight out of DONE on auto-reload.
  assign launch     = ((state == ST_IDLE) && start_evt && !stop_cmd) ||
                      ((state == ST_DONE) && auto_reload);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state       <= ST_IDLE;
      div_sh      <= '0;
      npulse_sh   <= '0;
      div_cnt     <= '0;
      issued      <= '0;
      clr_cnt     <= '0;
      cnt_pulse_o <= 1'b0;
      cnt_clr_o   <= 1'b0;
    end else begin
      cnt_pulse_o <= 1'b0;
      if (launch) begin
        div_sh    <= div_reg;
        npulse_sh <= npulse_reg;
        issued    <= '0;
        div_cnt   <= '0;
        clr_cnt   <= '0;
        cnt_clr_o <= clr_on_start;
        state     <= clr_on_start ? ST_CLEAR : ST_RUN;
      end else begin
        case (state)
          ST_CLEAR: begin
            if (stop_cmd) begin
              cnt_clr_o <= 1'b0;
              state     <= ST_IDLE;
            end else if (clr_cnt == CLR_W'(CLR_CYC - 1)) begin
              cnt_clr_o <= 1'b0;
              div_cnt   <= '0;
              state     <= ST_RUN;
            end else begin
              clr_cnt <= clr_cnt + CLR_W'(1);
            end
          end
          ST_RUN: begin
            if (stop_cmd) begin
              state <= ST_IDLE;
            end else if (div_cnt == period_max) begin
              cnt_pulse_o <= 1'b1;
              div_cnt     <= '0;
              issued      <= issued_inc;
              if (npulse_sh != '0 && issued_inc == npulse_sh) state <= ST_DONE;
            end else begin
              div_cnt <= div_cnt + DIV_W'(1);
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ripple_counter_seq.sv
// Directed self-checking bench for ripple_counter_seq (exercises RC_SEQ_EXT_TRIG_EN when defined).
module tb_ripple_counter_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic        cnt_pulse, cnt_clr, busy, irq;
`ifdef RC_SEQ_EXT_TRIG_EN
  logic        ext_trig = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  int pulse_cnt, first_pulse, clr_cnt, clr_first, irq_first, gap_bad;
  logic busy_seen;
  logic [31:0] rd;

  localparam logic [31:0] A_CTRL = 32'h0, A_DIV = 32'h4, A_NPULSE = 32'h8, A_STATUS = 32'hC;

  ripple_counter_seq dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (wdat),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (rdat),
    .cnt_pulse_o (cnt_pulse),
    .cnt_clr_o   (cnt_clr),
    .busy_o      (busy),
    .irq_o       (irq)
`ifdef RC_SEQ_EXT_TRIG_EN
    ,
    .ext_trig_i  (ext_trig)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d; sel = s;
    @(negedge clk);
    check("wr_ack", {31'b0, ack}, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    @(negedge clk);
    check("rd_ack", {31'b0, ack}, 32'd1);
    d = rdat;
    cyc = 1'b0; stb = 1'b0;
  endtask

  // Observe ncyc falling edges; gap != 0 requires uniform pulse spacing.
  task automatic watch(input int ncyc, input int gap);
    int last;
    pulse_cnt = 0; first_pulse = -1; clr_cnt = 0; clr_first = -1;
    irq_first = -1; gap_bad = 0; busy_seen = 1'b0; last = -1;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (cnt_pulse) begin
        pulse_cnt++;
        if (first_pulse < 0) first_pulse = i;
        if (gap != 0 && last >= 0 && (i - last) != gap) gap_bad = 1;
        last = i;
      end
      if (cnt_clr) begin
        clr_cnt++;
        if (clr_first < 0) clr_first = i;
      end
      if (irq && irq_first < 0) irq_first = i;
      if (busy) busy_seen = 1'b1;
    end
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_outputs", {27'b0, ack, cnt_pulse, cnt_clr, busy, irq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wb_read(A_CTRL, rd);   check("rst_ctrl", rd, 32'h0);
    wb_read(A_STATUS, rd); check("rst_status", rd, 32'h0);

    // Byte-lane writes on DIV
    wb_write(A_DIV, 32'h0000_1234, 4'hF);
    wb_write(A_DIV, 32'h0000_FF99, 4'h1);
    wb_read(A_DIV, rd);    check("div_bytelane", rd, 32'h0000_1299);

    // Basic burst: DIV=3 (period 4), NPULSE=5
    wb_write(A_DIV, 32'd3, 4'hF);
    wb_write(A_NPULSE, 32'd5, 4'hF);
    wb_write(A_CTRL, 32'h1, 4'hF);
    watch(30, 4);
    check("b1_pulses", 32'(pulse_cnt), 32'd5);
    check("b1_first", 32'(first_pulse), 32'd5);
    check("b1_gap", 32'(gap_bad), 32'd0);
    check("b1_noclr", 32'(clr_cnt), 32'd0);
    check("b1_busy_end", {31'b0, busy}, 32'd0);
    check("b1_irq_off", {31'b0, irq}, 32'd0);
    wb_read(A_STATUS, rd); check("b1_status", rd, 32'h0000_0502);

    // W1C done, then burst with clear-on-start
    wb_write(A_STATUS, 32'h2, 4'hF);
    wb_read(A_STATUS, rd); check("w1c_status", rd, 32'h0000_0500);
    wb_write(A_CTRL, 32'h9, 4'hF);
    watch(30, 4);
    check("b2_clr_cycles", 32'(clr_cnt), 32'd2);
    check("b2_clr_first", 32'(clr_first), 32'd1);
    check("b2_first", 32'(first_pulse), 32'd7);
    check("b2_pulses", 32'(pulse_cnt), 32'd5);
    check("b2_gap", 32'(gap_bad), 32'd0);

    // Free-run at minimum period, then stop
    wb_write(A_STATUS, 32'h2, 4'hF);
    wb_write(A_DIV, 32'd0, 4'hF);
    wb_write(A_NPULSE, 32'd0, 4'hF);
    wb_write(A_CTRL, 32'h1, 4'hF);
    watch(20, 2);
    check("fr_pulses", 32'(pulse_cnt), 32'd9);
    check("fr_first", 32'(first_pulse), 32'd3);
    check("fr_gap", 32'(gap_bad), 32'd0);
    wb_write(A_CTRL, 32'h2, 4'hF);
    watch(8, 0);
    check("fr_stop_pulses", 32'(pulse_cnt), 32'd0);
    check("fr_stop_busy", {31'b0, busy_seen}, 32'd0);
    wb_read(A_STATUS, rd); check("fr_done_busy", rd & 32'h3, 32'h0);

    // Auto-reload with interrupt: DIV=1 (period 2), NPULSE=2
    wb_write(A_DIV, 32'd1, 4'hF);
    wb_write(A_NPULSE, 32'd2, 4'hF);
    wb_write(A_CTRL, 32'h15, 4'hF);
    watch(12, 0);
    check("ar_pulses", 32'(pulse_cnt), 32'd4);
    check("ar_first", 32'(first_pulse), 32'd3);
    check("ar_irq_first", 32'(irq_first), 32'd6);
    check("ar_restarted", {31'b0, busy}, 32'd1);
    wb_write(A_CTRL, 32'h10, 4'hF);
    watch(10, 0);
    check("ar_idle", {31'b0, busy}, 32'd0);
    check("ar_irq_held", {31'b0, irq}, 32'd1);
    wb_write(A_STATUS, 32'h2, 4'hF);
    check("ar_irq_cleared", {31'b0, irq}, 32'd0);
    wb_read(A_STATUS, rd); check("ar_status", rd & 32'h3, 32'h0);

    // Start and stop in one write: stop wins
    wb_write(A_CTRL, 32'h3, 4'hF);
    watch(8, 0);
    check("ss_busy", {31'b0, busy_seen}, 32'd0);
    check("ss_pulses", 32'(pulse_cnt), 32'd0);

    // Reset asserted while a pulse is high
    wb_write(A_DIV, 32'd3, 4'hF);
    wb_write(A_NPULSE, 32'd0, 4'hF);
    wb_write(A_CTRL, 32'h1, 4'hF);
    watch(5, 0);
    check("mr_pulse_high", {31'b0, cnt_pulse}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check("mr_outputs", {27'b0, ack, cnt_pulse, cnt_clr, busy, irq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wb_read(A_DIV, rd);    check("mr_div", rd, 32'h0);
    wb_read(A_STATUS, rd); check("mr_status", rd, 32'h0);

`ifdef RC_SEQ_EXT_TRIG_EN
    begin
      int lat;
      lat = -1;
      ext_trig = 1'b1;
      for (int i = 1; i <= 5 && lat < 0; i++) begin
        @(negedge clk);
        if (busy) lat = i;
      end
      check("ext_latency", 32'(lat), 32'd3);
      wb_write(A_CTRL, 32'h2, 4'hF);
      watch(6, 0);
      check("ext_level_ignored", {31'b0, busy_seen}, 32'd0);
      ext_trig = 1'b0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
